// File: rtl/pc_jump_fetch.sv
// Fetch stage: owns the PC, forms PC+4 and the jump target, selects the
// redirect target and drives the IF/ID pipeline register. A redirect that
// arrives while the pipe is stalled is parked until the stall releases.
module pc_jump_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [27:0] jump_shifted,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic {
    NORMAL,
    PENDING
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pendTarget_q;
  logic [31:0] ifIdPc4_q;
  logic [31:0] ifIdInstr_q;
  logic        ifIdValid_q;

  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] redirectTarget;
  logic        redirect;

  // Address arithmetic and redirect selection; the jump borrows the upper
  // nibble of the jump instruction's own PC+4, and a taken branch outranks it.
  always_comb begin
    pcPlus4        = pc_q + 32'd4;
    jumpTarget     = {ifIdPc4_q[31:28], jump_shifted};
    redirect       = branch_taken | jump;
    redirectTarget = branch_taken ? branch_target : jumpTarget;
  end

  // PC, IF/ID and pending-redirect state machine; a redirect seen during a
  // stall is remembered (newest wins) and applied on the first unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      pc_q         <= RESET_PC;
      pendTarget_q <= 32'h0000_0000;
      ifIdPc4_q    <= 32'h0000_0000;
      ifIdInstr_q  <= NOP_INSTR;
      ifIdValid_q  <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (stall) begin
            if (redirect) begin
              pendTarget_q <= redirectTarget;
              state_q      <= PENDING;
            end
          end else if (redirect) begin
            pc_q        <= redirectTarget;
            ifIdPc4_q   <= 32'h0000_0000;
            ifIdInstr_q <= NOP_INSTR;
            ifIdValid_q <= 1'b0;
          end else begin
            pc_q        <= pcPlus4;
            ifIdPc4_q   <= pcPlus4;
            ifIdInstr_q <= instr_in;
            ifIdValid_q <= 1'b1;
          end
        end
        PENDING: begin
          if (stall) begin
            if (redirect) begin
              pendTarget_q <= redirectTarget;
            end
          end else begin
            pc_q        <= redirect ? redirectTarget : pendTarget_q;
            ifIdPc4_q   <= 32'h0000_0000;
            ifIdInstr_q <= NOP_INSTR;
            ifIdValid_q <= 1'b0;
            state_q     <= NORMAL;
          end
        end
        default: begin
          state_q <= NORMAL;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign if_id_pc4   = ifIdPc4_q;
  assign if_id_instr = ifIdInstr_q;
  assign if_id_valid = ifIdValid_q;

endmodule

// File: tb/tb_pc_jump_fetch.sv
// Testbench for pc_jump_fetch: table of directed cycles with hand-computed
// results, plus a hand-written asynchronous reset with a redirect parked.
module tb_pc_jump_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [27:0] jump_shifted;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int passCount;
  int totalCount;

  typedef struct {
    string       name;
    logic        stall;
    logic        jump;
    logic [27:0] js;
    logic        br;
    logic [31:0] bt;
    logic [31:0] expPc;
    logic [31:0] expPc4;
    logic [31:0] expInstr;
    logic        expValid;
  } vec_t;

  vec_t vecs[$];

  pc_jump_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump         (jump),
    .jump_shifted (jump_shifted),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .pc           (pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid)
  );

  // Instruction memory model: a distinct word derived from each address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign instr_in = memWord(pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] ePc,
                             input logic [31:0] ePc4, input logic [31:0] eInstr,
                             input logic eValid);
    totalCount += 4;
    if (pc === ePc) passCount++;
    else $display("[TB] FAIL %s pc: got %h want %h", name, pc, ePc);
    if (if_id_pc4 === ePc4) passCount++;
    else $display("[TB] FAIL %s if_id_pc4: got %h want %h", name, if_id_pc4, ePc4);
    if (if_id_instr === eInstr) passCount++;
    else $display("[TB] FAIL %s if_id_instr: got %h want %h", name, if_id_instr, eInstr);
    if (if_id_valid === eValid) passCount++;
    else $display("[TB] FAIL %s if_id_valid: got %b want %b", name, if_id_valid, eValid);
  endtask

  task automatic applyStimulus(input logic s, input logic j, input logic [27:0] js,
                               input logic b, input logic [31:0] bt);
    stall         = s;
    jump          = j;
    jump_shifted  = js;
    branch_taken  = b;
    branch_target = bt;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic s, input logic j,
                              input logic [27:0] js, input logic b, input logic [31:0] bt,
                              input logic [31:0] p, input logic [31:0] p4,
                              input logic [31:0] ins, input logic v);
    vec_t r;
    r.name = n; r.stall = s; r.jump = j; r.js = js; r.br = b; r.bt = bt;
    r.expPc = p; r.expPc4 = p4; r.expInstr = ins; r.expValid = v;
    return r;
  endfunction

  initial begin
    passCount  = 0;
    totalCount = 0;

    //               name        stl jmp js            br  bt             pc             pc4            instr                    v
    vecs.push_back(mk("seq0",     0, 0, 28'h0,        0, 32'h0,         32'h4,         32'h4,         memWord(32'h0),          1));
    vecs.push_back(mk("seq1",     0, 0, 28'h0,        0, 32'h0,         32'h8,         32'h8,         memWord(32'h4),          1));
    vecs.push_back(mk("brHi",     0, 0, 28'h0,        1, 32'h1000_0004, 32'h1000_0004, 32'h0,         32'h0,                   0));
    vecs.push_back(mk("seqHi",    0, 0, 28'h0,        0, 32'h0,         32'h1000_0008, 32'h1000_0008, memWord(32'h1000_0004),  1));
    vecs.push_back(mk("jump",     0, 1, 28'h000_0040, 0, 32'h0,         32'h1000_0040, 32'h0,         32'h0,                   0));
    vecs.push_back(mk("jumpTgt",  0, 0, 28'h0,        0, 32'h0,         32'h1000_0044, 32'h1000_0044, memWord(32'h1000_0040),  1));
    vecs.push_back(mk("brWins",   0, 1, 28'h000_0040, 1, 32'h200,       32'h200,       32'h0,         32'h0,                   0));
    vecs.push_back(mk("after200", 0, 0, 28'h0,        0, 32'h0,         32'h204,       32'h204,       memWord(32'h200),        1));
    vecs.push_back(mk("stlJmp",   1, 1, 28'h000_0100, 0, 32'h0,         32'h204,       32'h204,       memWord(32'h200),        1));
    vecs.push_back(mk("stl2",     1, 0, 28'h0,        0, 32'h0,         32'h204,       32'h204,       memWord(32'h200),        1));
    vecs.push_back(mk("stl3",     1, 0, 28'h0,        0, 32'h0,         32'h204,       32'h204,       memWord(32'h200),        1));
    vecs.push_back(mk("pendRel",  0, 0, 28'h0,        0, 32'h0,         32'h100,       32'h0,         32'h0,                   0));
    vecs.push_back(mk("after100", 0, 0, 28'h0,        0, 32'h0,         32'h104,       32'h104,       memWord(32'h100),        1));
    vecs.push_back(mk("stlBr300", 1, 0, 28'h0,        1, 32'h300,       32'h104,       32'h104,       memWord(32'h100),        1));
    vecs.push_back(mk("stlHold",  1, 0, 28'h0,        0, 32'h0,         32'h104,       32'h104,       memWord(32'h100),        1));
    vecs.push_back(mk("stlBr400", 1, 0, 28'h0,        1, 32'h400,       32'h104,       32'h104,       memWord(32'h100),        1));
    vecs.push_back(mk("newest",   0, 0, 28'h0,        0, 32'h0,         32'h400,       32'h0,         32'h0,                   0));
    vecs.push_back(mk("after400", 0, 0, 28'h0,        0, 32'h0,         32'h404,       32'h404,       memWord(32'h400),        1));
    vecs.push_back(mk("stlBr500", 1, 0, 28'h0,        1, 32'h500,       32'h404,       32'h404,       memWord(32'h400),        1));
    vecs.push_back(mk("relBr600", 0, 0, 28'h0,        1, 32'h600,       32'h600,       32'h0,         32'h0,                   0));
    vecs.push_back(mk("after600", 0, 0, 28'h0,        0, 32'h0,         32'h604,       32'h604,       memWord(32'h600),        1));
    vecs.push_back(mk("stlPlain", 1, 0, 28'h0,        0, 32'h0,         32'h604,       32'h604,       memWord(32'h600),        1));
    vecs.push_back(mk("noPend",   0, 0, 28'h0,        0, 32'h0,         32'h608,       32'h608,       memWord(32'h604),        1));
    vecs.push_back(mk("brTop",    0, 0, 28'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,                   0));
    vecs.push_back(mk("wrap",     0, 0, 28'h0,        0, 32'h0,         32'h0,         32'h0,         memWord(32'hFFFF_FFFC),  1));
    vecs.push_back(mk("postWrap", 0, 0, 28'h0,        0, 32'h0,         32'h4,         32'h4,         memWord(32'h0),          1));

    rst           = 1'b1;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_shifted  = 28'h0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    #12;
    checkOutput("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stall, vecs[i].jump, vecs[i].js, vecs[i].br, vecs[i].bt);
      checkOutput(vecs[i].name, vecs[i].expPc, vecs[i].expPc4, vecs[i].expInstr, vecs[i].expValid);
    end

    // Park a jump to 0x80 while stalled at pc=0x40, then reset mid-cycle
    applyStimulus(0, 0, 28'h0, 1, 32'h40);
    checkOutput("to40", 32'h40, 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 1, 28'h000_0080, 0, 32'h0);
    checkOutput("park80", 32'h40, 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst", 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1, 0, 28'h0, 0, 32'h0);
    checkOutput("rstHeld", 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    applyStimulus(0, 0, 28'h0, 0, 32'h0);
    checkOutput("rstSeq0", 32'h4, 32'h4, memWord(32'h0), 1'b1);
    applyStimulus(0, 0, 28'h0, 0, 32'h0);
    checkOutput("rstSeq1", 32'h8, 32'h8, memWord(32'h4), 1'b1);
    applyStimulus(0, 0, 28'h0, 0, 32'h0);
    checkOutput("rstSeq2", 32'hC, 32'hC, memWord(32'h8), 1'b1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
